// File: rtl/instruction_encoder.sv
// Field-level instruction encoder: packs request fields into 16-bit words, buffers
// them with their target addresses in a 2-entry FIFO and writes them out over a ready/valid memory port.
module instruction_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_opcode,
    input  logic [1:0]  in_op,
    input  logic [2:0]  in_rn,
    input  logic [2:0]  in_rd,
    input  logic [2:0]  in_rm,
    input  logic [1:0]  in_shift,
    input  logic [15:0] in_imm,
    input  logic        in_last,
    output logic        mem_write,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [8:0]  word_count
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, ERR = 2'd3} state_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } entry_t;

    state_t             state, state_n;
    entry_t             fifo [2];
    entry_t             head;
    logic               wr_ptr, rd_ptr;
    logic [1:0]         count;
    logic [7:0]         acc_addr;
    logic               addr_spent;
    logic signed [15:0] imm_s;
    logic [15:0]        enc;
    logic               illegal, imm_bad;
    logic [1:0]         code;
    logic               accept, req_err, push, pop, begin_run;

    assign imm_s = in_imm;

    // Immediate range is only checked for formats that actually carry one.
    always_comb begin
        enc     = '0;
        illegal = 1'b0;
        imm_bad = 1'b0;
        case (in_opcode)
            3'b110: begin
                if (in_op == 2'b10) begin
                    enc     = {3'b110, 2'b10, in_rn, in_imm[7:0]};
                    imm_bad = (imm_s < -16'sd128) || (imm_s > 16'sd127);
                end else if (in_op == 2'b00) begin
                    enc = {3'b110, 2'b00, 3'b000, in_rd, in_shift, in_rm};
                end else begin
                    illegal = 1'b1;
                end
            end
            3'b101: begin
                enc = {3'b101, in_op,
                       (in_op == 2'b11) ? 3'b000 : in_rn,
                       (in_op == 2'b01) ? 3'b000 : in_rd,
                       in_shift, in_rm};
            end
            3'b011, 3'b100: begin
                if (in_op == 2'b00) begin
                    enc     = {in_opcode, 2'b00, in_rn, in_rd, in_imm[4:0]};
                    imm_bad = (imm_s < -16'sd16) || (imm_s > 16'sd15);
                end else begin
                    illegal = 1'b1;
                end
            end
            3'b111: begin
                if (in_op == 2'b00) enc = 16'hE000;
                else                illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign code      = illegal ? 2'b11 : imm_bad ? 2'b01 : addr_spent ? 2'b10 : 2'b00;
    assign in_ready  = (state == RUN) && (count != 2'd2);
    assign accept    = in_valid && in_ready;
    assign req_err   = accept && (code != 2'b00);
    assign push      = accept && (code == 2'b00);
    assign pop       = mem_write && mem_ready;
    assign begin_run = start && ((state == IDLE) || (state == ERR));

    always_comb begin
        state_n = state;
        done    = 1'b0;
        case (state)
            IDLE:  if (start) state_n = RUN;
            RUN: begin
                if (req_err)              state_n = ERR;
                else if (push && in_last) state_n = DRAIN;
            end
            DRAIN: begin
                if (count == 2'd0) begin
                    state_n = IDLE;
                    done    = 1'b1;
                end
            end
            ERR:   if (start) state_n = RUN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Storage needs no reset: outputs are gated by count.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= '{addr: acc_addr, data: enc};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Address 0xFF is usable once; afterwards further requests are refused rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_addr   <= 8'd0;
            addr_spent <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            word_count <= 9'd0;
        end else begin
            if (pop && (word_count != 9'd256)) word_count <= word_count + 9'd1;
            if (begin_run) begin
                acc_addr   <= base_addr;
                addr_spent <= 1'b0;
                if (state == ERR) begin
                    err        <= 1'b0;
                    err_code   <= 2'b00;
                    word_count <= 9'd0;
                end
            end else if (push) begin
                if (acc_addr == 8'hFF) addr_spent <= 1'b1;
                else                   acc_addr   <= acc_addr + 8'd1;
            end
            if (req_err) begin
                err      <= 1'b1;
                err_code <= code;
            end
        end
    end

    assign head      = fifo[rd_ptr];
    assign mem_write = (count != 2'd0);
    assign mem_addr  = mem_write ? head.addr : 8'd0;
    assign mem_wdata = mem_write ? head.data : 16'd0;
    assign busy      = (state == RUN) || (state == DRAIN) || (count != 2'd0);

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: stimulus queues expected writes,
// a negedge monitor pops and compares each completed memory write.
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready, in_last;
    logic [7:0]  base_addr;
    logic [2:0]  in_opcode, in_rn, in_rd, in_rm;
    logic [1:0]  in_op, in_shift;
    logic [15:0] in_imm;
    logic        mem_write, mem_ready, busy, done, err;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  err_code;
    logic [8:0]  word_count;

    instruction_encoder dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_op(in_op),
        .in_rn(in_rn), .in_rd(in_rd), .in_rm(in_rm), .in_shift(in_shift),
        .in_imm(in_imm), .in_last(in_last), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done),
        .err(err), .err_code(err_code), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    logic        held_v = 1'b0;
    logic [7:0]  held_a;
    logic [15:0] held_d;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // Monitor: stall stability plus in-order write scoreboard
    always @(negedge clk) begin
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_write", mem_write, 1);
                check("stall_addr", mem_addr, held_a);
                check("stall_data", mem_wdata, held_d);
            end
            if (mem_write && mem_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_wdata);
                end else begin
                    mon_e = q.pop_front();
                    check("wr_addr", mem_addr, mon_e.addr);
                    check("wr_data", mem_wdata, mon_e.data);
                end
                held_v = 1'b0;
            end else if (mem_write) begin
                held_v = 1'b1;
                held_a = mem_addr;
                held_d = mem_wdata;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_mem_write"}, mem_write, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_err_code"}, err_code, 0);
        check({tag, "_word_count"}, word_count, 0);
    endtask

    task automatic do_reset(input string tag);
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        reset    = 1'b1;
        #1;
        check_idle(tag);
        q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic session(input logic [7:0] base);
        base_addr = base;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [2:0] opc, input logic [1:0] op, input logic [2:0] rn,
                        input logic [2:0] rd, input logic [2:0] rm, input logic [1:0] sh,
                        input logic [15:0] imm, input logic last, input bit exp_push,
                        input logic [7:0] ea, input logic [15:0] ed);
        bit got = 1'b0;
        if (exp_push) q.push_back('{addr: ea, data: ed});
        in_opcode = opc; in_op = op; in_rn = rn; in_rd = rd; in_rm = rm;
        in_shift = sh; in_imm = imm; in_last = last; in_valid = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1 got = 1'b1;
            end
        end
        if (!got) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("handshake", got, 1);
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        repeat (12) @(negedge clk) if (done) c++;
        check(name, c, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        in_opcode = '0; in_op = '0; in_rn = '0; in_rd = '0; in_rm = '0; in_shift = '0;
        in_imm = '0; mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Basic MOV imm session
        do_reset("rst1");
        mem_ready = 1'b1;
        session(8'h10);
        send(3'b110, 2'b10, 3'd3, 3'd0, 3'd0, 2'd0, 16'hFFFB, 1'b1, 1'b1, 8'h10, 16'hD3FB);
        wait_done("t2_done_pulses");
        check("t2_word_count", word_count, 1);
        check("t2_busy", busy, 0);
        check("t2_err", err, 0);
        check("t2_q_empty", q.size(), 0);

        // Stalled writes with a full FIFO
        do_reset("rst2");
        mem_ready = 1'b0;
        session(8'h40);
        send(3'b101, 2'b00, 3'd1, 3'd2, 3'd0, 2'd1, 16'h0000, 1'b0, 1'b1, 8'h40, 16'hA148);
        send(3'b100, 2'b00, 3'd2, 3'd1, 3'd0, 2'd0, 16'hFFFF, 1'b0, 1'b1, 8'h41, 16'h823F);
        check("t3_in_ready_full", in_ready, 0);
        check("t3_busy", busy, 1);
        check("t3_head_addr", mem_addr, 8'h40);
        check("t3_head_data", mem_wdata, 16'hA148);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 mem_ready = 1'b1;
        send(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b1, 1'b1, 8'h42, 16'hE000);
        wait_done("t3_done_pulses");
        check("t3_word_count", word_count, 3);
        check("t3_q_empty", q.size(), 0);

        // Immediate out of range, then recovery via start
        do_reset("rst3");
        mem_ready = 1'b1;
        session(8'h00);
        send(3'b011, 2'b00, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0010, 1'b1, 1'b0, 8'h00, 16'h0000);
        check("t4_err", err, 1);
        check("t4_err_code", err_code, 2'b01);
        check("t4_in_ready", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_in_ready_hold", in_ready, 0);
        check("t4_mem_write", mem_write, 0);
        session(8'h80);
        check("t4_err_clear", err, 0);
        check("t4_code_clear", err_code, 0);
        check("t4_in_ready_run", in_ready, 1);
        send(3'b110, 2'b00, 3'd0, 3'd5, 3'd7, 2'd2, 16'h1234, 1'b1, 1'b1, 8'h80, 16'hC0B7);
        wait_done("t4_done_pulses");
        check("t4_word_count", word_count, 1);

        // Address space exhaustion
        do_reset("rst4");
        mem_ready = 1'b1;
        session(8'hFE);
        send(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b0, 1'b1, 8'hFE, 16'hE000);
        send(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b0, 1'b1, 8'hFF, 16'hE000);
        send(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000);
        check("t5_err", err, 1);
        check("t5_err_code", err_code, 2'b10);
        repeat (4) @(posedge clk);
        #1;
        check("t5_q_empty", q.size(), 0);
        check("t5_word_count", word_count, 2);
        check("t5_mem_write", mem_write, 0);

        // Illegal opcode / op combinations
        do_reset("rst5");
        mem_ready = 1'b1;
        session(8'h00);
        send(3'b010, 2'b00, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        check("t6_code_opc010", err_code, 2'b11);
        session(8'h00);
        check("t6_err_clear", err, 0);
        send(3'b110, 2'b01, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        check("t6_code_mov01", err_code, 2'b11);
        check("t6_mem_write", mem_write, 0);

        // Field forcing and immediate range boundaries
        do_reset("rst6");
        mem_ready = 1'b1;
        session(8'h00);
        send(3'b101, 2'b01, 3'd7, 3'd7, 3'd5, 2'd3, 16'h7FFF, 1'b0, 1'b1, 8'h00, 16'hAF1D);
        send(3'b101, 2'b11, 3'd7, 3'd2, 3'd1, 2'd0, 16'h0000, 1'b0, 1'b1, 8'h01, 16'hB841);
        send(3'b110, 2'b10, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFF80, 1'b0, 1'b1, 8'h02, 16'hD080);
        send(3'b110, 2'b10, 3'd7, 3'd0, 3'd0, 2'd0, 16'h007F, 1'b0, 1'b1, 8'h03, 16'hD77F);
        send(3'b011, 2'b00, 3'd1, 3'd3, 3'd0, 2'd0, 16'hFFF0, 1'b0, 1'b1, 8'h04, 16'h6170);
        send(3'b100, 2'b00, 3'd0, 3'd0, 3'd0, 2'd0, 16'h000F, 1'b1, 1'b1, 8'h05, 16'h800F);
        wait_done("t7_done_pulses");
        check("t7_word_count", word_count, 6);
        session(8'h30);
        send(3'b110, 2'b10, 3'd1, 3'd0, 3'd0, 2'd0, 16'h0080, 1'b0, 1'b0, 8'h00, 16'h0000);
        check("t7_code_mov128", err_code, 2'b01);
        session(8'h30);
        send(3'b011, 2'b00, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFFEF, 1'b0, 1'b0, 8'h00, 16'h0000);
        check("t7_code_ldr_m17", err_code, 2'b01);

        // Reset during a stalled write
        do_reset("rst7");
        mem_ready = 1'b0;
        session(8'h55);
        send(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b1, 1'b1, 8'h55, 16'hE000);
        check("t8_stall_write", mem_write, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_idle("t8");
        q.delete();
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        check("t8_no_retry", mem_write, 0);
        check("t8_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have: clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: start  in  1  begin session; base_addr  in  8  first write address.
REQ-004 SHALL have: in_valid  in  1, in_ready  out  1  field-level request handshake; transfer when both high on a clock edge.
REQ-005 SHALL have: in_opcode  in  3, in_op  in  2, in_rn/in_rd/in_rm  in  3 each, in_shift  in  2, in_imm  in  16 (signed), in_last  in  1  marks final request.
REQ-006 SHALL have: mem_write  out  1, mem_addr  out  8, mem_wdata  out  16, mem_ready  in  1  write handshake; complete when mem_write and mem_ready are both high on a clock edge.
REQ-007 SHALL have: busy  out  1, done  out  1 (one-cycle pulse), err  out  1 (sticky), err_code  out  2, word_count  out  9.

Function
REQ-008 SHALL encode fields per opcode/op (bits 15:13 opcode, 12:11 op):
 - 110/10 MOV imm: {110,10,Rn,imm[7:0]}; imm range -128..127.
 - 110/00 MOV reg: {110,00,000,Rd,shift,Rm}.
 - 101/any ALU: {101,op,Rn,Rd,shift,Rm}; Rd field forced 000 when op=01; Rn field forced 000 when op=11.
 - 011/00 LDR, 100/00 STR: {opc,00,Rn,Rd,imm[4:0]}; imm range -16..15.
 - 111/00 HALT: {111,00,11'b0}.
REQ-009 SHALL treat any other opcode/op combination as illegal: err_code 11.
REQ-010 SHALL flag in_imm outside the required sign-extended range as err_code 01; in_imm ignored for formats without an immediate.
REQ-011 SHALL implement FSM IDLE, RUN, DRAIN, ERR: IDLE->RUN on start (loads base_addr into the accept address); RUN->DRAIN on acceptance of a legal word with in_last; DRAIN->IDLE when FIFO empty, with done high for exactly that transition cycle; RUN or DRAIN->ERR on error detection; ERR->RUN on start (clears err, err_code, word_count).
REQ-012 SHALL ignore start in RUN and DRAIN.
REQ-013 SHALL buffer encoded words with their addresses in a 2-entry FIFO; in_ready = (state==RUN) and (FIFO count<2); no same-cycle bypass when full.
REQ-014 SHALL allow simultaneous push and pop; count unchanged.
REQ-015 SHALL present the FIFO head on mem_write/mem_addr/mem_wdata no earlier than the cycle after acceptance, and hold all three stable until mem_ready.
REQ-016 SHALL assign addresses at acceptance, incrementing from base_addr; after 0xFF is assigned, the next accepted request SHALL set err_code 10 instead of wrapping.
REQ-017 On error, SHALL discard the offending request, latch err=1 and err_code, drop in_ready, and still write words already in the FIFO.
REQ-018 SHALL increment word_count on each completed memory write, saturating at 256.
REQ-019 busy SHALL be high in RUN and DRAIN, and while the FIFO is non-empty.

Reset
REQ-020 On reset, SHALL immediately force: state IDLE, FIFO empty, mem_write 0, mem_addr 0, mem_wdata 0, in_ready 0, busy 0, done 0, err 0, err_code 0, word_count 0.
REQ-021 Reset during a stalled write SHALL abandon the write; no retry after release.

Verification
REQ-022 start, base 0x10; MOV imm op=10 rn=3 imm=0xFFFB last; mem_ready=1 -> one write, addr 0x10, data 0xD3FB; done pulse; word_count=1.
REQ-023 ALU op=00 rn=1 rd=2 shift=01 rm=0, then STR rn=2 rd=1 imm=-1 last, mem_ready low 3 cycles -> 0xA148 held stable through the stall, then 0x823F at next address; in_ready low while FIFO holds 2.
REQ-024 LDR imm=16 -> no write; err=1, err_code=01; in_ready=0 until start.
REQ-025 base 0xFE, three HALT requests -> 0xE000 written at 0xFE and 0xFF; third request rejected with err_code=10.
REQ-026 opcode 010 -> err_code=11; opcode 110 op 01 -> err_code=11.
REQ-027 reset asserted mid-stall with mem_write high -> all outputs 0 in the same cycle, asynchronously.
